sha_param_hash_padder: RTL and testbench
========================================

// Module: sha_param_hash_padder
// PURPOSE
//  Parametrised, buffered padder for the second pass of a double SHA-256 (or SHA-224) hash.
//  - Accepts a finished HashState digest plus a sideband tag over a valid/ready handshake.
//  - Buffers it in a DEPTH-entry FIFO.
//  - Emits the single padded 16-word message block in the configured word layout.
//  - Sits between the first-pass hash core and the second-pass message scheduler.
// PARAMETERS
//  DIGEST_WORDS  8  digest words used, a..h order, range 1..8 (7 = SHA-224)
//  LAYOUT        1  0 = standard: padded[i]=W[i]; 1 = reversed-wrap: padded[i]=W[(16-i)%16]
//  DEPTH         2  FIFO entries, >=1, need not be a power of two
//  TAG_W         32 sideband tag width (e.g. nonce), >=1
// PORTS
//  clk          in   1            clock
//  rst          in   1            asynchronous reset, active-high
//  flush        in   1            synchronous FIFO clear
//  in_valid     in   1            in_state/in_tag valid
//  in_ready     out  1            block can accept this cycle
//  in_state     in   HashState    first-pass digest (a..h, 32b each)
//  in_tag       in   TAG_W        tag carried with the digest
//  out_valid    out  1            padded/out_tag valid
//  out_ready    in   1            consumer accepts head entry
//  padded       out  [15:0][31:0] padded message block
//  out_tag      out  TAG_W        tag of head entry
//  occupancy    out  clog2(DEPTH+1)  entries held
//  blk_count    out  32           blocks delivered since reset
// BEHAVIOUR
//  Message words (standard order):
//  - W[0..D-1] = a,b,... ; W[D] = 32'h80000000; W[D+1..14] = 0; W[15] = 32*D (D = DIGEST_WORDS).
//  Handshake rules:
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
//  - in_ready = !flush & (occupancy < DEPTH). No push while full, even if a pop occurs in the same cycle.
//  - out_valid = (occupancy != 0). Head data stays stable while out_valid & !out_ready.
//  - When out_valid = 0, padded and out_tag are driven to all-zero.
//  Storage and latency:
//  - The FIFO stores D digest words plus the tag. Padding is formed combinationally from the head entry.
//  - No combinational path from in_* to out_*.
//  - Latency is 1 cycle: an entry pushed in cycle N into an empty FIFO gives out_valid in N+1.
//  - Throughput is 1/cycle when DEPTH >= 2; with DEPTH = 1 it is 1 per 2 cycles.
//  Boundary conditions:
//  - Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
//  - Pointers wrap from DEPTH-1 to 0.
//  - flush clears pointers and occupancy at the next edge and has priority over pop. No push is possible
//    during flush. A pop in the flush cycle is not counted.
//  - Reset (async, any time, including mid-transfer): occupancy = 0, pointers = 0, blk_count = 0,
//    out_valid = 0, padded = 0, out_tag = 0. FIFO storage contents need not be reset.
//  - blk_count increments on each pop and wraps 32'hFFFFFFFF -> 0. flush does not clear it.
//  - Unused in_state words (index >= D) are ignored.
// STRUCTURE
//  Shared package sha_pkg:
//  - HashState typedef and SHA_PAD_WORD = 32'h80000000.
//  - pad_layout_e {PAD_STANDARD, PAD_REVERSED_WRAP}.
//  - Function sha_pad_block(words, D, layout) returning [15:0][31:0].
//  Sub-module sha_pad_fifo:
//  - Generic WIDTH/DEPTH valid/ready FIFO with flush and occupancy.
//  - Instantiated with WIDTH = 32*DIGEST_WORDS + TAG_W.
//  Top level: packing, padding/layout mux, output zeroing, blk_count.
// TESTING
//  1. D=8, LAYOUT=1, state a..h = 1..8, tag 0xABCD, out_ready=1:
//     next cycle padded[0]=1, [1]=256, [2..7]=0, [8]=0x80000000, [9..15]=8,7,6,5,4,3,2; out_tag=0xABCD.
//  2. D=7, LAYOUT=0, same state:
//     padded[0..6]=1..7, [7]=0x80000000, [8..14]=0, [15]=224; in_state.h ignored.
//  3. DEPTH=2, out_ready=0, push 3 entries:
//     first two accepted; in_ready=0 with occupancy=2. Raise out_ready: entries emerge in order,
//     blk_count=2, then the third entry is accepted.
//  4. Continuous in_valid and out_ready=1 for 10 cycles (DEPTH=2):
//     10 blocks out back-to-back, occupancy stays 1, output order matches input order.
//  5. Occupancy 2, assert flush with out_ready=1:
//     next cycle occupancy=0, out_valid=0, padded=0, blk_count unchanged.
//  6. Assert rst asynchronously mid-stream (occupancy 1):
//     all outputs zero before the next edge; after release, a fresh push gives 1-cycle latency.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 padding types and the helper that builds the padded second-pass block.
package sha_pkg;

    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } HashState;

    localparam logic [31:0] SHA_PAD_WORD = 32'h80000000;

    typedef enum logic {
        PAD_STANDARD      = 1'b0,
        PAD_REVERSED_WRAP = 1'b1
    } pad_layout_e;

    typedef logic [15:0][31:0] block_t;

    // words[0] is digest word a; d is the number of digest words used (1..8).
    function automatic block_t sha_pad_block(input logic [7:0][31:0] words,
                                             input int unsigned d,
                                             input pad_layout_e layout);
        block_t w;
        block_t p;
        logic [3:0] j;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < d)
                w[i] = words[i[2:0]];
            else if (i == d)
                w[i] = SHA_PAD_WORD;
            else if (i == 15)
                w[i] = d * 32;
            else
                w[i] = '0;
        end
        for (int unsigned i = 0; i < 16; i++) begin
            j = 4'(16 - i);
            p[i] = (layout == PAD_STANDARD) ? w[i] : w[j];
        end
        return p;
    endfunction

endpackage

// File: rtl/sha_pad_fifo.sv
// Generic valid/ready FIFO with synchronous flush and occupancy; DEPTH need not be a power of two.
module sha_pad_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full blocks a push even when a pop happens in the same cycle.
    assign in_ready  = !flush && (occupancy < OCC_W'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)
                occupancy <= occupancy + 1'b1;
            else if (pop && !push)
                occupancy <= occupancy - 1'b1;
        end
    end

    // Storage is deliberately left unreset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/sha_param_hash_padder.sv
// Buffers first-pass digests with a tag and presents the padded second-pass message block.
module sha_param_hash_padder
    import sha_pkg::*;
#(
    parameter  int          DIGEST_WORDS = 8,
    parameter  pad_layout_e LAYOUT       = PAD_REVERSED_WRAP,
    parameter  int          DEPTH        = 2,
    parameter  int          TAG_W        = 32,
    localparam int          OCC_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  HashState          in_state,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0][31:0] padded,
    output logic [TAG_W-1:0]  out_tag,
    output logic [OCC_W-1:0]  occupancy,
    output logic [31:0]       blk_count
);

    localparam int WIDTH = 32 * DIGEST_WORDS + TAG_W;

    logic [7:0][31:0] in_words;
    logic [7:0][31:0] head_words;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] head_data;
    logic             head_valid;

    assign in_words  = {in_state.h, in_state.g, in_state.f, in_state.e,
                        in_state.d, in_state.c, in_state.b, in_state.a};
    // Only the used digest words are stored; the tag sits above them.
    assign push_data = {in_tag, in_words[DIGEST_WORDS-1:0]};

    sha_pad_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (push_data),
        .out_valid (head_valid),
        .out_ready (out_ready),
        .out_data  (head_data),
        .occupancy (occupancy)
    );

    always_comb begin
        head_words = '0;
        for (int i = 0; i < DIGEST_WORDS; i++)
            head_words[i] = head_data[32*i +: 32];
    end

    assign out_valid = head_valid;
    assign padded    = head_valid ? sha_pad_block(head_words, DIGEST_WORDS, LAYOUT) : '0;
    assign out_tag   = head_valid ? head_data[WIDTH-1 -: TAG_W] : '0;

    // A pop coinciding with flush is discarded, so it is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_count <= '0;
        else if (head_valid && out_ready && !flush)
            blk_count <= blk_count + 32'd1;
    end

endmodule

// File: tb/tb_sha_param_hash_padder.sv
// Directed bench for sha_param_hash_padder: scoreboard on the D=8 reversed instance, spot checks on D=7.
module tb_sha_param_hash_padder;
    import sha_pkg::*;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    HashState          in_state;
    logic [31:0]       in_tag;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    logic [15:0][31:0] padded;
    logic [31:0]       out_tag;
    logic [1:0]        occupancy;
    logic [31:0]       blk_count;

    logic              in_ready7;
    logic              out_valid7;
    logic [15:0][31:0] padded7;
    logic [31:0]       out_tag7;
    logic [1:0]        occupancy7;
    logic [31:0]       blk_count7;

    logic [543:0]      exp_q[$];
    logic [7:0][31:0]  sw;
    logic [15:0][31:0] e1;
    logic [15:0][31:0] e2;
    int                n_cmp;
    int                n_err;
    int                exp_blk;

    sha_param_hash_padder #(
        .DIGEST_WORDS (8), .LAYOUT (PAD_REVERSED_WRAP), .DEPTH (2), .TAG_W (32)
    ) dut (
        .clk (clk), .rst (rst), .flush (flush), .in_valid (in_valid), .in_ready (in_ready),
        .in_state (in_state), .in_tag (in_tag), .out_valid (out_valid), .out_ready (out_ready),
        .padded (padded), .out_tag (out_tag), .occupancy (occupancy), .blk_count (blk_count)
    );

    sha_param_hash_padder #(
        .DIGEST_WORDS (7), .LAYOUT (PAD_STANDARD), .DEPTH (2), .TAG_W (32)
    ) dut7 (
        .clk (clk), .rst (rst), .flush (flush), .in_valid (in_valid), .in_ready (in_ready7),
        .in_state (in_state), .in_tag (in_tag), .out_valid (out_valid7), .out_ready (1'b1),
        .padded (padded7), .out_tag (out_tag7), .occupancy (occupancy7), .blk_count (blk_count7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference padding written from the message-word definition.
    function automatic logic [15:0][31:0] exp_block(input logic [7:0][31:0] w, input int d,
                                                    input bit rev);
        logic [15:0][31:0] m;
        logic [15:0][31:0] r;
        m = '0;
        for (int k = 0; k < d; k++) m[k] = w[k];
        m[d]  = 32'h80000000;
        m[15] = 32 * d;
        if (!rev) return m;
        r[0] = m[0];
        for (int k = 1; k < 16; k++) r[k] = m[16 - k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [543:0] obs, input logic [543:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0][31:0] w, input logic [31:0] t);
        sw       = w;
        in_state = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
        in_tag   = t;
    endtask

    // Observe handshakes just after inputs settle, then advance to the next falling edge.
    task automatic cycle();
        logic [543:0] e;
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {543'd0, out_valid}, 544'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard", {out_tag, padded}, e);
                end
                exp_blk++;
            end
            if (in_valid && in_ready)
                exp_q.push_back({in_tag, exp_block(sw, 8, 1'b1)});
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0][31:0] w;
        n_cmp = 0; n_err = 0; exp_blk = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) w[k] = 32'(k + 1);
        drive(w, 32'h0);

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {543'd0, out_valid}, 544'd0);
        chk("rst_occupancy", {542'd0, occupancy}, 544'd0);
        chk("rst_padded", {32'd0, padded}, 544'd0);
        chk("rst_blk_count", {512'd0, blk_count}, 544'd0);
        chk("rst_in_ready", {543'd0, in_ready}, 544'd1);
        rst = 1'b0;
        @(negedge clk);

        // Reversed-wrap D=8 and standard D=7 from the same digest 1..8
        e1 = '0; e1[0] = 32'd1; e1[1] = 32'd256; e1[8] = 32'h80000000;
        for (int k = 9; k < 16; k++) e1[k] = 32'(17 - k);
        e2 = '0; e2[7] = 32'h80000000; e2[15] = 32'd224;
        for (int k = 0; k < 7; k++) e2[k] = 32'(k + 1);
        out_ready = 1'b1; in_valid = 1'b1;
        drive(w, 32'hABCD);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid", {543'd0, out_valid}, 544'd1);
        chk("t1_padded", {32'd0, padded}, {32'd0, e1});
        chk("t1_out_tag", {512'd0, out_tag}, {512'd0, 32'hABCD});
        chk("t2_padded", {32'd0, padded7}, {32'd0, e2});
        chk("t2_out_tag", {512'd0, out_tag7}, {512'd0, 32'hABCD});
        cycle();

        // Backpressure: two accepted, third held until space frees
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) w[k] = 32'h100 + 32'(k);
        drive(w, 32'h11); cycle();
        for (int k = 0; k < 8; k++) w[k] = 32'h200 + 32'(k);
        drive(w, 32'h22); cycle();
        for (int k = 0; k < 8; k++) w[k] = 32'h300 + 32'(k);
        drive(w, 32'h33);
        #1;
        chk("t3_full_in_ready", {543'd0, in_ready}, 544'd0);
        chk("t3_full_occupancy", {542'd0, occupancy}, 544'd2);
        cycle();
        out_ready = 1'b1;
        cycle();
        chk("t3_in_ready_after_pop", {543'd0, in_ready}, 544'd1);
        cycle();
        chk("t3_blk_count", {512'd0, blk_count}, {512'd0, 32'(exp_blk)});
        in_valid = 1'b0;
        cycle();
        chk("t3_drained", {542'd0, occupancy}, 544'd0);

        // Streaming: ten back-to-back transfers
        in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < 8; k++) w[k] = $urandom;
            drive(w, $urandom);
            if (n > 0) chk("t4_occupancy", {542'd0, occupancy}, 544'd1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("t4_blk_count", {512'd0, blk_count}, {512'd0, 32'(exp_blk)});

        // Flush with two entries held and out_ready high
        out_ready = 1'b0; in_valid = 1'b1;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 8; k++) w[k] = $urandom_range(1, 1000);
            drive(w, 32'(n + 5));
            cycle();
        end
        in_valid = 1'b0;
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("t5_occupancy", {542'd0, occupancy}, 544'd0);
        chk("t5_out_valid", {543'd0, out_valid}, 544'd0);
        chk("t5_padded", {32'd0, padded}, 544'd0);
        chk("t5_blk_count", {512'd0, blk_count}, {512'd0, 32'(exp_blk)});
        @(negedge clk);

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) w[k] = 32'hC0DE0000 + 32'(k);
        drive(w, 32'h77);
        cycle();
        in_valid = 1'b0;
        chk("t6_pre_occupancy", {542'd0, occupancy}, 544'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_out_valid", {543'd0, out_valid}, 544'd0);
        chk("t6_occupancy", {542'd0, occupancy}, 544'd0);
        chk("t6_padded", {32'd0, padded}, 544'd0);
        chk("t6_out_tag", {512'd0, out_tag}, 544'd0);
        chk("t6_blk_count", {512'd0, blk_count}, 544'd0);
        exp_q.delete();
        exp_blk = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) w[k] = 32'hF00D0000 + 32'(k);
        drive(w, 32'h99);
        #1;
        chk("t6_push_cycle_out_valid", {543'd0, out_valid}, 544'd0);
        cycle();
        in_valid = 1'b0;
        chk("t6_latency_out_valid", {543'd0, out_valid}, 544'd1);
        cycle();
        chk("final_queue_empty", 544'(exp_q.size()), 544'd0);
        chk("final_blk_count", {512'd0, blk_count}, {512'd0, 32'(exp_blk)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
